sha256d_block_sequencer: RTL and testbench
==========================================

SHA256D_BLOCK_SEQUENCER -- requirements
Module: sha256d_block_sequencer

Interface
REQ-001 SHALL have ports clk, input, 1, rising-edge clock; all state updates on this edge.
REQ-002 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-003 SHALL have port blk_valid, input, 1: blk_data is a valid pre-padded 512-bit SHA-256 message block.
REQ-004 SHALL have port blk_ready, output, 1: the sequencer can accept a block this cycle.
REQ-005 SHALL have port blk_data, input, 512: message block, MSB-first, padding already applied by the producer.
REQ-006 SHALL have port blk_last, input, 1: qualified by blk_valid; marks the final block of the job.
REQ-007 SHALL have port dig_valid, output, 1: digest holds a result.
REQ-008 SHALL have port dig_ready, input, 1: the consumer accepts the digest.
REQ-009 SHALL have port digest, output, 256: result chaining state, H0 in bits 255:224.
REQ-010 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-011 SHALL have port blk_count, output, 8: number of blocks absorbed in the current job, saturating.

Function
REQ-012 SHALL instantiate exactly one combinational sha256 compression unit (data, state, next_state) and perform at most one compression per cycle.
REQ-013 SHALL implement FSM states IDLE, ABSORB, FINAL and DONE.
REQ-014 In IDLE, blk_ready=1; on blk_valid the unit SHALL register chain <= compress(blk_data, H0) and set blk_count=1.
REQ-015 In IDLE, after the accept the FSM SHALL go to FINAL if blk_last=1, else to ABSORB.
REQ-016 In ABSORB, blk_ready=1; on blk_valid the unit SHALL register chain <= compress(blk_data, chain) and increment blk_count, saturating at 255.
REQ-017 In ABSORB, after the accept the FSM SHALL go to FINAL if blk_last=1, else stay in ABSORB.
REQ-018 In ABSORB, when blk_valid=0 the unit SHALL hold chain and blk_count; there is no timeout.
REQ-019 In FINAL, blk_ready=0; the unit SHALL register chain <= compress({chain, 256'h8000...0100}, H0), then go to DONE.
REQ-020 In DONE, dig_valid=1 and digest=chain, both held stable while dig_ready=0; blk_ready=0.
REQ-021 In DONE, on dig_ready=1 the FSM SHALL go to IDLE; no block is accepted in the handshake cycle.
REQ-022 Latency SHALL be: last block accepted at cycle t, dig_valid=1 at t+2.
REQ-023 dig_ready asserted outside DONE SHALL be ignored, and blk_valid asserted while blk_ready=0 SHALL be ignored, consuming no data.
REQ-024 Back-to-back accepts SHALL sustain one block per cycle in ABSORB.
REQ-025 A single-block job with blk_last in IDLE SHALL be legal.
REQ-026 blk_count SHALL clear to 0 on the transition from DONE to IDLE.

Reset
REQ-027 When rst_n=0 at a clock edge, the unit SHALL set the FSM to IDLE, chain=H0, blk_count=0, dig_valid=0, busy=0.
REQ-028 After reset, blk_ready SHALL be 1 in the first cycle after rst_n rises.
REQ-029 Reset asserted mid-job (ABSORB, FINAL or DONE) SHALL abort the job with no digest produced; partial state is discarded.
REQ-030 While rst_n=0, digest SHALL be H0 and SHALL NOT expose a stale chain.

Configuration
REQ-031 Macro SHA256D_DOUBLE_HASH_EN SHALL control the second compression.
REQ-032 With SHA256D_DOUBLE_HASH_EN defined, FINAL is present and the result is double-SHA-256.
REQ-033 With SHA256D_DOUBLE_HASH_EN undefined, FINAL is removed: the last accept goes directly to DONE, digest is single SHA-256, and latency is t+1.

Verification
REQ-034 The bench SHALL cover: macro on, one block "abc" padded with blk_last=1 -> dig_valid at t+2, digest=4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358, blk_count=1.
REQ-035 The bench SHALL cover: macro off, same block -> dig_valid at t+1, digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-036 The bench SHALL cover: macro on, empty-message padded block (80000...0000) -> digest=5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456.
REQ-037 The bench SHALL cover: 7-block job with blk_valid gaps and dig_ready held low 5 cycles -> digest matches the software model, stable for all 5 cycles, blk_ready=0 throughout DONE, blk_count=7.
REQ-038 The bench SHALL cover: rst_n=0 for one cycle after block 3 of a 7-block job -> dig_valid never rises, blk_count=0, next "abc" job correct.
REQ-039 The bench SHALL cover: 300-block job -> blk_count saturates at 255 and the digest matches the model.

Source files
------------

// File: rtl/sha256d_block_sequencer.sv
// SHA-256 block sequencer: absorbs pre-padded 512-bit blocks through one combinational compression unit.
// Build option SHA256D_DOUBLE_HASH_EN adds a FINAL pass that re-hashes the chain (double SHA-256).

module sha256_compress (
    input  logic [511:0] data,
    input  logic [255:0] state,
    output logic [255:0] next_state
);
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    // All 64 rounds are unrolled into one combinational cone.
    always_comb begin
        for (int t = 0; t < 16; t++) begin
            w[t] = data[511 - 32*t -: 32];
        end
        for (int t = 16; t < 64; t++) begin
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        a = state[255:224];
        b = state[223:192];
        c = state[191:160];
        d = state[159:128];
        e = state[127:96];
        f = state[95:64];
        g = state[63:32];
        h = state[31:0];
        t1 = '0;
        t2 = '0;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g;
            g = f;
            f = e;
            e = d + t1;
            d = c;
            c = b;
            b = a;
            a = t1 + t2;
        end
        next_state = {a + state[255:224], b + state[223:192], c + state[191:160], d + state[159:128],
                      e + state[127:96],  f + state[95:64],   g + state[63:32],   h + state[31:0]};
    end
endmodule

module sha256d_block_sequencer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_last,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] digest,
    output logic         busy,
    output logic [7:0]   blk_count
);
    localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

`ifdef SHA256D_DOUBLE_HASH_EN
    // Padding for a 256-bit message: 0x80 marker byte, zeros, bit length 256.
    localparam logic [255:0] PAD = {32'h80000000, 192'd0, 32'h00000100};

    typedef enum logic [1:0] {IDLE = 2'd0, ABSORB = 2'd1, FINAL = 2'd2, DONE = 2'd3} state_t;
    localparam state_t LAST_ST = FINAL;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ABSORB = 2'd1, DONE = 2'd3} state_t;
    localparam state_t LAST_ST = DONE;
`endif

    state_t       state_q, state_d;
    logic [255:0] chain_q, chain_d;
    logic [7:0]   cnt_q, cnt_d;

    logic [511:0] comp_data;
    logic [255:0] comp_state;
    logic [255:0] comp_out;

    sha256_compress u_compress (
        .data       (comp_data),
        .state      (comp_state),
        .next_state (comp_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chain_q <= H0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        chain_d    = chain_q;
        cnt_d      = cnt_q;
        comp_data  = blk_data;
        comp_state = chain_q;
        blk_ready  = 1'b0;
        dig_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                // A new job always starts from the initial hash, whatever the chain still holds.
                blk_ready  = 1'b1;
                comp_state = H0;
                if (blk_valid) begin
                    chain_d = comp_out;
                    cnt_d   = 8'd1;
                    state_d = blk_last ? LAST_ST : ABSORB;
                end
            end
            ABSORB: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    chain_d = comp_out;
                    if (cnt_q != 8'hff) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    state_d = blk_last ? LAST_ST : ABSORB;
                end
            end
`ifdef SHA256D_DOUBLE_HASH_EN
            FINAL: begin
                comp_data  = {chain_q, PAD};
                comp_state = H0;
                chain_d    = comp_out;
                state_d    = DONE;
            end
`endif
            DONE: begin
                dig_valid = 1'b1;
                if (dig_ready) begin
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign digest    = rst_n ? chain_q : H0;
    assign busy      = (state_q != IDLE);
    assign blk_count = cnt_q;
endmodule

// File: tb/tb_sha256d_block_sequencer.sv
// Randomized self-checking bench for sha256d_block_sequencer against a message-level SHA-256 model.
// Expectations follow SHA256D_DOUBLE_HASH_EN in the same way as the design build.

module tb_sha256d_block_sequencer;
    localparam logic [255:0] H0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
`ifdef SHA256D_DOUBLE_HASH_EN
    localparam int LAT = 2;
    localparam logic [255:0] ABC_DIG   = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
    localparam logic [255:0] EMPTY_DIG = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;
`else
    localparam int LAT = 1;
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
`endif

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst_n, blk_valid, blk_ready, blk_last, dig_valid, dig_ready, busy;
    logic [511:0] blk_data;
    logic [255:0] digest;
    logic [7:0]   blk_count;

    always #5 clk = ~clk;

    sha256d_block_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .digest    (digest),
        .busy      (busy),
        .blk_count (blk_count)
    );

    int           tests = 0;
    int           fails = 0;
    logic [255:0] exp_q [$];
    logic         m_chk  = 1'b0;
    logic [7:0]   m_cnt  = 8'd0;
    logic         m_busy = 1'b0;
    logic [511:0] job_blks [300];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression with a 16-word rolling message schedule.
    function automatic logic [255:0] m_compress(input logic [511:0] blk, input logic [255:0] st);
        logic [31:0] win [16];
        logic [31:0] v [8];
        logic [31:0] wt, x2, x15, temp1, temp2;
        logic [255:0] res;
        for (int i = 0; i < 8; i++)  v[i]   = st[255 - 32*i -: 32];
        for (int i = 0; i < 16; i++) win[i] = blk[511 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                wt = win[t];
            end else begin
                x2  = win[(t - 2) % 16];
                x15 = win[(t - 15) % 16];
                wt  = (rr(x2, 17) ^ rr(x2, 19) ^ (x2 >> 10)) + win[(t - 7) % 16]
                    + (rr(x15, 7) ^ rr(x15, 18) ^ (x15 >> 3)) + win[t % 16];
                win[t % 16] = wt;
            end
            temp1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                  + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wt;
            temp2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                  + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + temp1;
            v[0] = temp1 + temp2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = st[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    function automatic logic [255:0] m_job(input int n);
        logic [255:0] ch;
        ch = H0;
        for (int i = 0; i < n; i++) ch = m_compress(job_blks[i], ch);
`ifdef SHA256D_DOUBLE_HASH_EN
        ch = m_compress({ch, 32'h80000000, 192'd0, 32'h00000100}, H0);
`endif
        return ch;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = $urandom();
        return r;
    endfunction

    // Per-cycle checker against the model state kept by the stimulus.
    always @(negedge clk) begin
        if (rst_n === 1'b0) begin
            chk("reset_digest_h0", digest, H0);
        end else if (m_chk) begin
            chk("blk_count", blk_count, m_cnt);
            chk("busy", busy, m_busy);
            if (dig_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_dig_valid", dig_valid, 1'b0);
                end else begin
                    chk("digest", digest, exp_q[0]);
                    chk("blk_ready_in_done", blk_ready, 1'b0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [511:0] d, input logic last);
        int waited;
        waited    = 0;
        blk_valid = 1'b1;
        blk_data  = d;
        blk_last  = last;
        while (!blk_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!blk_ready) begin
            chk("accept_timeout", blk_ready, 1'b1);
            blk_valid = 1'b0;
            return;
        end
        step();
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        blk_data  = rand_blk();
        m_busy    = 1'b1;
        m_cnt     = (m_cnt == 8'hff) ? 8'hff : m_cnt + 8'd1;
    endtask

    task automatic run_job(input string name, input int n, input int max_gap, input int hold,
                           input logic [255:0] lit, input bit use_lit);
        logic [255:0] exp;
        int waited;
        exp = m_job(n);
        if (use_lit) chk({name, "_model"}, exp, lit);
        exp_q.push_back(exp);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                blk_valid = 1'b0;
                blk_data  = rand_blk();
                dig_ready = 1'($urandom_range(0, 1));
                step();
            end
            send_block(job_blks[i], 1'(i == n - 1));
        end
        dig_ready = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            chk({name, "_latency"}, dig_valid, 1'(k == LAT));
            if (k < LAT) step();
        end
        waited = 0;
        while (!dig_valid && waited < 20) begin
            step();
            waited++;
        end
        if (!dig_valid) begin
            chk({name, "_dig_timeout"}, dig_valid, 1'b1);
            void'(exp_q.pop_front());
            return;
        end
        if (use_lit) chk({name, "_digest"}, digest, lit);
        chk({name, "_count"}, blk_count, (n > 255) ? 255 : n);
        // Offered blocks during DONE and in the handshake cycle must be ignored.
        blk_valid = 1'b1;
        blk_data  = rand_blk();
        repeat (hold) begin
            step();
            chk({name, "_hold_valid"}, dig_valid, 1'b1);
        end
        dig_ready = 1'b1;
        step();
        dig_ready = 1'b0;
        blk_valid = 1'b0;
        void'(exp_q.pop_front());
        m_busy = 1'b0;
        m_cnt  = 8'd0;
        chk({name, "_after_valid"}, dig_valid, 1'b0);
        chk({name, "_after_ready"}, blk_ready, 1'b1);
        $display("[TB] job %s: %0d blocks, digest %h", name, n, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        blk_data  = '0;
        dig_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_chk = 1'b1;
        chk("reset_blk_ready", blk_ready, 1'b1);
        chk("reset_dig_valid", dig_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_blk_count", blk_count, 8'd0);

        job_blks[0] = {32'h61626380, 448'd0, 32'h00000018};
        run_job("abc", 1, 2, 2, ABC_DIG, 1'b1);

        job_blks[0] = {32'h80000000, 480'd0};
        run_job("empty", 1, 0, 0, EMPTY_DIG, 1'b1);

        for (int i = 0; i < 7; i++) job_blks[i] = rand_blk();
        run_job("gap7", 7, 3, 5, '0, 1'b0);

        // Abort: reset for one edge after the third block of a 7-block job.
        for (int i = 0; i < 7; i++) job_blks[i] = rand_blk();
        for (int i = 0; i < 3; i++) send_block(job_blks[i], 1'b0);
        m_chk = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n  = 1'b1;
        m_cnt  = 8'd0;
        m_busy = 1'b0;
        m_chk  = 1'b1;
        chk("abort_blk_count", blk_count, 8'd0);
        chk("abort_blk_ready", blk_ready, 1'b1);
        repeat (8) begin
            chk("abort_dig_valid", dig_valid, 1'b0);
            step();
        end
        $display("[TB] job abort: 3 of 7 blocks then reset");

        job_blks[0] = {32'h61626380, 448'd0, 32'h00000018};
        run_job("abc_after_abort", 1, 1, 1, ABC_DIG, 1'b1);

        for (int j = 0; j < 3; j++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) job_blks[i] = rand_blk();
            run_job("random", n, 2, $urandom_range(0, 3), '0, 1'b0);
        end

        for (int i = 0; i < 300; i++) job_blks[i] = rand_blk();
        run_job("sat300", 300, 0, 1, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
